// File: rtl/osf_pipe_arbiter_pkg.sv
// Shared constants and types for the osf pipe arbiter: header magic,
// field widths and the frame FSM state encoding.
package osf_pipe_arbiter_pkg;

  localparam logic [3:0] OPA_HDR_MAGIC = 4'hA;
  localparam int         W_SEQ         = 8;
  localparam int         W_CHID        = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } opa_state_t;

endpackage

// File: rtl/osf_pipe_arbiter_if.sv
// Bundle of the osf-side capture inputs, FIFO-side outputs and status lines.
// master = the side feeding samples / consuming FIFO words, slave = arbiter.
interface osf_pipe_arbiter_if #(
  parameter int N_ADC      = 8,
  parameter int W_ADC_DATA = 18,
  parameter int W_EP       = 16
);
  logic [N_ADC-1:0]            chan_mask_in;
  logic [N_ADC-1:0]            osf_data_valid_in;
  logic [N_ADC*W_ADC_DATA-1:0] osf_data_packed_in;
  logic                        fifo_full_in;
  logic [W_EP-1:0]             data_out;
  logic                        data_valid_out;
  logic [15:0]                 drop_count_out;
  logic                        busy_out;

  modport master (
    output chan_mask_in, osf_data_valid_in, osf_data_packed_in, fifo_full_in,
    input  data_out, data_valid_out, drop_count_out, busy_out
  );

  modport slave (
    input  chan_mask_in, osf_data_valid_in, osf_data_packed_in, fifo_full_in,
    output data_out, data_valid_out, drop_count_out, busy_out
  );
endinterface

// File: rtl/osf_pipe_arbiter_rr.sv
// Combinational round-robin picker: the first set request found searching
// ptr+1, ptr+2, ... ptr+N (mod N) wins.
module rr_arbiter #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx
);

  // Scan farthest-to-nearest so the nearest requester after ptr is the last write
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = N; k >= 1; k--) begin
      if (req[IDX_W'((int'(ptr) + k) % N)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IDX_W'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/osf_pipe_arbiter.sv
// Shares the bulk-transfer pipe FIFO between N_ADC oversample-filter channels.
// Each channel has a one-deep hold register; a round-robin grant picks a
// pending channel and a 3-state FSM emits a header word then the data word.
module osf_pipe_arbiter
  import osf_pipe_arbiter_pkg::*;
#(
  parameter int N_ADC      = 8,
  parameter int W_ADC_DATA = 18,
  parameter int W_EP       = 16
) (
  input logic               clk50_in,
  input logic               reset_in,
  osf_pipe_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(N_ADC);

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [4:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {12'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  logic [W_EP-1:0]   hold [N_ADC];
  logic [N_ADC-1:0]  pending;
  logic [N_ADC-1:0]  pending_nxt;
  logic [N_ADC-1:0]  eligible;
  logic [4:0]        drop_inc;
  opa_state_t        state;
  logic [IDX_W-1:0]  chan;
  logic [W_EP-1:0]   frame_word;
  logic [W_SEQ-1:0]  seq;
  logic [IDX_W-1:0]  rr_ptr;
  logic              gnt_valid;
  logic [IDX_W-1:0]  gnt_idx;
  logic              grant_now;
  logic [W_CHID-1:0] chan_id;
  logic              unused_lsbs;

  // Sample LSBs below the pipe word are intentionally discarded
  assign unused_lsbs = ^bus.osf_data_packed_in;

  assign eligible  = pending & bus.chan_mask_in;
  assign grant_now = (state == ST_IDLE) && gnt_valid;
  assign chan_id   = W_CHID'(chan);

  rr_arbiter #(.N(N_ADC), .IDX_W(IDX_W)) u_rr (
    .req       (eligible),
    .ptr       (rr_ptr),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Next pending flags and number of overwritten samples this cycle
  always_comb begin
    pending_nxt = pending;
    drop_inc    = '0;
    for (int i = 0; i < N_ADC; i++) begin
      if (!bus.chan_mask_in[i]) begin
        pending_nxt[i] = 1'b0;
      end else if (bus.osf_data_valid_in[i]) begin
        pending_nxt[i] = 1'b1;
        if (pending[i] && !(grant_now && gnt_idx == IDX_W'(i)))
          drop_inc = drop_inc + 5'd1;
      end else if (grant_now && gnt_idx == IDX_W'(i)) begin
        pending_nxt[i] = 1'b0;
      end
    end
  end

  // Per-channel capture: the newest enabled sample replaces the hold word
  for (genvar g = 0; g < N_ADC; g++) begin : g_hold
    always_ff @(posedge clk50_in) begin
      if (bus.osf_data_valid_in[g] && bus.chan_mask_in[g])
        hold[g] <= bus.osf_data_packed_in[g*W_ADC_DATA + W_ADC_DATA - 1 -: W_EP];
    end
  end

  // Capture control: pending flags, drop counter, busy status
  always_ff @(posedge clk50_in) begin
    if (reset_in) begin
      pending            <= '0;
      bus.drop_count_out <= '0;
      bus.busy_out       <= 1'b0;
    end else begin
      pending            <= pending_nxt;
      bus.drop_count_out <= sat_add16(bus.drop_count_out, drop_inc);
      bus.busy_out       <= (state != ST_IDLE) || (|eligible);
    end
  end

  // Frame FSM: latch winner in IDLE, header word in HDR, data word in DATA
  always_ff @(posedge clk50_in) begin
    if (reset_in) begin
      state              <= ST_IDLE;
      bus.data_out       <= '0;
      bus.data_valid_out <= 1'b0;
      seq                <= '0;
      rr_ptr             <= IDX_W'(N_ADC - 1);
    end else begin
      bus.data_valid_out <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (gnt_valid) begin
            chan       <= gnt_idx;
            frame_word <= hold[gnt_idx];
            state      <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (!bus.fifo_full_in) begin
            bus.data_out       <= W_EP'({OPA_HDR_MAGIC, chan_id, seq});
            bus.data_valid_out <= 1'b1;
            state              <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (!bus.fifo_full_in) begin
            bus.data_out       <= frame_word;
            bus.data_valid_out <= 1'b1;
            seq                <= seq + 1'b1;
            rr_ptr             <= chan;
            state              <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_osf_pipe_arbiter.sv
// Self-checking bench for osf_pipe_arbiter: directed scenarios plus random
// traffic, compared every cycle against a frame-level reference model.
module tb_osf_pipe_arbiter;
  localparam int N  = 8;
  localparam int WD = 18;
  localparam int WE = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  osf_pipe_arbiter_if #(.N_ADC(N), .W_ADC_DATA(WD), .W_EP(WE)) bus ();

  osf_pipe_arbiter #(.N_ADC(N), .W_ADC_DATA(WD), .W_EP(WE)) dut (
    .clk50_in (clk),
    .reset_in (rst),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state (frame phase: 0 waiting, 1 header due, 2 data due)
  logic [N-1:0] m_pend;
  logic [15:0]  m_hold [N];
  int           m_phase, m_chan, m_seq, m_rr, m_drop;
  logic [15:0]  m_buf, m_do;
  logic         m_dv, m_busy;

  logic [15:0] got[$];
  int          vstep[$];
  int          stepcnt;
  int          frames;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_phase = 0; m_seq = 0; m_rr = N - 1;
    m_do = '0; m_dv = 1'b0; m_drop = 0; m_busy = 1'b0;
  endtask

  // One clock of the reference, using the inputs as seen at the edge
  task automatic model_clock();
    int g;
    logic [N-1:0] elig;
    if (rst) begin
      model_reset();
      return;
    end
    elig = m_pend & bus.chan_mask_in;
    m_busy = (m_phase != 0) || (elig != '0);
    g = -1;
    if (m_phase == 0)
      for (int k = 1; k <= N; k++)
        if (g < 0 && elig[(m_rr + k) % N]) g = (m_rr + k) % N;
    m_dv = 1'b0;
    if (m_phase == 1) begin
      if (!bus.fifo_full_in) begin
        m_dv = 1'b1; m_do = {4'hA, 4'(m_chan), 8'(m_seq)}; m_phase = 2;
      end
    end else if (m_phase == 2) begin
      if (!bus.fifo_full_in) begin
        m_dv = 1'b1; m_do = m_buf; m_seq = (m_seq + 1) % 256; m_rr = m_chan; m_phase = 0;
      end
    end else if (g >= 0) begin
      m_chan = g; m_buf = m_hold[g]; m_phase = 1;
    end
    for (int i = 0; i < N; i++) begin
      if (!bus.chan_mask_in[i]) begin
        m_pend[i] = 1'b0;
      end else if (bus.osf_data_valid_in[i]) begin
        if (m_pend[i] && g != i && m_drop < 65535) m_drop++;
        m_hold[i] = bus.osf_data_packed_in[i*WD + WD - 1 -: WE];
        m_pend[i] = 1'b1;
      end else if (g == i) begin
        m_pend[i] = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    stepcnt++;
    #1;
    chk("data_valid_out", 32'(bus.data_valid_out), 32'(m_dv));
    chk("data_out", 32'(bus.data_out), 32'(m_do));
    chk("drop_count_out", 32'(bus.drop_count_out), 32'(m_drop));
    chk("busy_out", 32'(bus.busy_out), 32'(m_busy));
    if (bus.data_valid_out) begin
      got.push_back(bus.data_out);
      vstep.push_back(stepcnt);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.osf_data_valid_in = '0;
    bus.fifo_full_in = 1'b0;
    step();
    rst = 1'b0;
    got.delete();
    vstep.delete();
    stepcnt = 0;
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++)
      bus.osf_data_packed_in[i*WD +: WD] = WD'($urandom);
  endtask

  initial begin
    rst = 1'b1;
    bus.chan_mask_in = '0;
    bus.osf_data_valid_in = '0;
    bus.osf_data_packed_in = '0;
    bus.fifo_full_in = 1'b0;
    stepcnt = 0;
    model_reset();
    for (int i = 0; i < N; i++) m_hold[i] = '0;
    step();
    step();
    chk("reset_data_out", 32'(bus.data_out), 32'h0);
    chk("reset_valid", 32'(bus.data_valid_out), 32'h0);
    chk("reset_drops", 32'(bus.drop_count_out), 32'h0);
    chk("reset_busy", 32'(bus.busy_out), 32'h0);
    rst = 1'b0;

    // Single channel frame and latency
    do_reset();
    bus.chan_mask_in = 8'h01;
    bus.osf_data_packed_in[0 +: WD] = 18'h2ABCD;
    bus.osf_data_valid_in = 8'h01;
    step();
    bus.osf_data_valid_in = '0;
    for (int s = 0; s < 6; s++) step();
    chk("t1_words", 32'(got.size()), 32'd2);
    chk("t1_hdr", 32'(got[0]), 32'hA000);
    chk("t1_data", 32'(got[1]), 32'hAAF3);
    chk("t1_hdr_step", 32'(vstep[0]), 32'd3);
    chk("t1_data_step", 32'(vstep[1]), 32'd4);

    // Fairness: all channels strobe at once
    do_reset();
    bus.chan_mask_in = 8'hFF;
    rand_data();
    bus.osf_data_valid_in = 8'hFF;
    step();
    bus.osf_data_valid_in = '0;
    for (int s = 0; s < 30; s++) step();
    chk("t2_words", 32'(got.size()), 32'd16);
    for (int k = 0; k < N; k++)
      chk("t2_hdr", 32'(got[2*k]), 32'({4'hA, 4'(k), 8'(k)}));
    chk("t2_drops", 32'(bus.drop_count_out), 32'd0);

    // Overflow on one channel
    do_reset();
    bus.chan_mask_in = 8'h08;
    bus.osf_data_valid_in = 8'h08;
    for (int s = 0; s < 12; s++) begin
      rand_data();
      step();
    end
    bus.osf_data_valid_in = '0;
    for (int s = 0; s < 12; s++) step();
    frames = got.size() / 2;
    chk("t3_frames_range", 32'(frames >= 4 && frames <= 5), 32'd1);
    chk("t3_drops", 32'(bus.drop_count_out), 32'(12 - frames));

    // Backpressure while a header is due
    do_reset();
    bus.chan_mask_in = 8'h01;
    rand_data();
    bus.osf_data_valid_in = 8'h01;
    step();
    bus.osf_data_valid_in = '0;
    bus.fifo_full_in = 1'b1;
    for (int s = 0; s < 10; s++) step();
    chk("t4_stalled", 32'(got.size()), 32'd0);
    bus.fifo_full_in = 1'b0;
    for (int s = 0; s < 5; s++) step();
    chk("t4_words", 32'(got.size()), 32'd2);
    chk("t4_hdr", 32'(got[0]), 32'hA000);
    chk("t4_adjacent", 32'(vstep[1] - vstep[0]), 32'd1);

    // Mask cleared before grant
    do_reset();
    bus.chan_mask_in = 8'h04;
    rand_data();
    bus.osf_data_valid_in = 8'h04;
    step();
    bus.osf_data_valid_in = '0;
    bus.chan_mask_in = 8'h00;
    for (int s = 0; s < 6; s++) step();
    chk("t5_no_frame", 32'(got.size()), 32'd0);
    chk("t5_drops", 32'(bus.drop_count_out), 32'd0);

    // Reset while the data word is stalled
    do_reset();
    bus.chan_mask_in = 8'h01;
    bus.osf_data_valid_in = 8'h01;
    for (int s = 0; s < 3; s++) begin
      rand_data();
      step();
    end
    bus.osf_data_valid_in = '0;
    bus.fifo_full_in = 1'b1;
    step();
    chk("t6_pre_drops", 32'(bus.drop_count_out), 32'd1);
    rst = 1'b1;
    step();
    chk("t6_rst_valid", 32'(bus.data_valid_out), 32'd0);
    chk("t6_rst_drops", 32'(bus.drop_count_out), 32'd0);
    rst = 1'b0;
    bus.fifo_full_in = 1'b0;
    got.delete();
    rand_data();
    bus.osf_data_valid_in = 8'h01;
    step();
    bus.osf_data_valid_in = '0;
    for (int s = 0; s < 5; s++) step();
    chk("t6_restart_hdr", 32'(got[0]), 32'hA000);

    // Random traffic against the model
    do_reset();
    bus.chan_mask_in = 8'($urandom);
    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 19) == 0) bus.chan_mask_in = 8'($urandom);
      bus.osf_data_valid_in = 8'($urandom & $urandom);
      bus.fifo_full_in = ($urandom_range(0, 4) == 0);
      rst = ($urandom_range(0, 99) == 0);
      rand_data();
      step();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
